ceespu_int_ctrl: RTL
====================

Name: ceespu_int_ctrl

Overview:
- Interrupt controller for the ceespu core.
- Collects NUM_SRC external interrupt lines, latches them as pending, masks them, and picks the highest-priority one.
- Drives the decode stage's I_int / I_int_vector request pair and holds it until decode returns O_int_ack.
- Sits between the peripherals and the decode stage, and enforces a hold-off gap after each serviced interrupt.

Parameters:
- VEC_W, 2, width of the interrupt vector; must match the decode I_int_vector width.
- NUM_SRC, 4, number of interrupt sources; must equal 1<<VEC_W.
- HOLDOFF, 2, cycles the controller stays quiet after an ack before it may raise another request (0..15).

Ports:
- I_clk  in  1  clock
- I_rst  in  1  synchronous reset, active-high
- I_irq  in  NUM_SRC  raw interrupt lines from peripherals
- I_int_ack  in  1  decode O_int_ack; decode has taken the interrupt
- I_mask_we  in  1  write strobe for the mask register
- I_mask_wdata  in  NUM_SRC  new mask; 1 = source enabled
- I_clr_we  in  1  write strobe for software clear of pending bits
- I_clr_wdata  in  NUM_SRC  1 = clear that pending bit
- O_int  out  1  interrupt request to decode I_int
- O_int_vector  out  VEC_W  index of the source being requested
- O_pending  out  NUM_SRC  pending register, for status readback
- O_mask  out  NUM_SRC  current mask register
- O_busy  out  1  high in REQ or HOLD

Behaviour:
- Reset is synchronous on I_rst, which is active-high; clock is I_clk.
- Reset values:
  - O_int=0, O_int_vector=0, O_pending=0, O_mask=all ones, O_busy=0.
  - State=IDLE, hold counter=0, irq edge-detect register=0.
- Edge detection:
  - irq_q <= I_irq every cycle.
  - rise = I_irq & ~irq_q.
  - A rise sets the matching pending bit; a source held high produces one pending event only.
- Pending register update, in this priority per bit:
  1. Set by rise (a set always wins).
  2. Clear by ack of the serviced source.
  3. Clear by I_clr_we & I_clr_wdata.
- Mask:
  - Written on I_mask_we, taking effect the next cycle.
  - eligible = O_pending & O_mask.
  - The mask never clears pending bits.
- Priority: fixed, lowest index highest (bit 0 beats bit 3).
- FSM:
  - IDLE: if eligible != 0, go to REQ on the next edge; register O_int=1 and O_int_vector = highest-priority eligible index. Request latency is 2 cycles from an I_irq rise to O_int high.
  - REQ:
    - O_int and O_int_vector are held stable; they are not re-arbitrated even if a higher-priority source arrives or the mask changes.
    - On an edge with I_int_ack=1: O_int <= 0, clear pending[O_int_vector], then go to HOLD (or to IDLE if HOLDOFF=0).
    - Decode ignores I_int after taking it because its interrupts_enabled drops, so one extra cycle of O_int after decode's decision is harmless.
  - HOLD:
    - Counter loads HOLDOFF-1 on entry and decrements each cycle; at 0, go to IDLE.
    - O_int=0 throughout.
    - Pending bits still accumulate.
- I_int_ack in IDLE or HOLD is ignored: no state or pending change.
- A rise on the serviced source in the same cycle as its ack leaves the pending bit set, and it is re-requested after HOLD.
- A software clear of the serviced bit while in REQ clears the bit, but the request stays up until ack. The request is committed.
- I_rst in any state returns to the reset values next edge; an outstanding request is dropped without an ack.
- O_busy = (state != IDLE), registered alongside the state.

Optional Feature:
- Macro: CEESPU_INT_LEVEL_EN.
- Defined:
  - Sources are level-sensitive; the edge detector and pending latch are bypassed: O_pending = I_irq, registered with 1-cycle delay.
  - Ack and software clear have no effect on pending; the peripheral must drop its line.
  - In HOLD the line is re-sampled, so a source still high is re-requested after HOLDOFF.
- Undefined: edge-latched behaviour as described above.

Test Plan:
- Single source: after reset, pulse I_irq=4'b0100 for 1 cycle -> O_int=1, O_int_vector=2 two cycles later; O_pending=4'b0100. Ack 1 cycle -> O_int=0 next edge, O_pending=0, O_busy high for 2 more cycles then 0.
- Priority and no preemption: raise bits 3 and 1 together -> vector=1. While in REQ raise bit 0 -> vector stays 1. After ack and HOLD -> vector=0, then vector=3.
- Mask: write mask=4'b1110, pulse bit 0 -> O_pending=4'b0001, O_int stays 0. Write mask=4'b1111 -> O_int=1, vector=0 two cycles after the write.
- Simultaneous set and clear: with vector=2 in REQ, a rise on bit 2 in the same cycle as ack -> O_pending[2] stays 1, and vector=2 is requested again after HOLD.
- Reset mid-request: in REQ with vector=1, assert I_rst 1 cycle -> O_int=0, O_pending=0, O_mask=4'b1111, O_busy=0. A spurious I_int_ack afterwards causes no change.
- With CEESPU_INT_LEVEL_EN: hold I_irq[3]=1 -> request, ack, HOLD, then re-request of vector 3. Drop the line -> no further request.

Source files
------------

// File: rtl/ceespu_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ceespu_int_ctrl
// Purpose  : Interrupt controller for the ceespu core. Latches rising edges of
//            NUM_SRC peripheral lines as pending bits, masks them, selects the
//            highest-priority (lowest index) eligible source and drives the
//            decode stage's I_int / I_int_vector pair until it is acknowledged.
//            After each ack the controller stays quiet for HOLDOFF cycles.
// Macro    : CEESPU_INT_LEVEL_EN - when defined, sources are level-sensitive:
//            pending simply mirrors I_irq one cycle later; ack and software
//            clear have no effect on pending.
// Ports    : I_clk        clock
//            I_rst        synchronous reset, active-high
//            I_irq        raw interrupt lines
//            I_int_ack    decode has taken the interrupt
//            I_mask_we    mask register write strobe
//            I_mask_wdata new mask, 1 = source enabled
//            I_clr_we     software clear strobe for pending bits
//            I_clr_wdata  1 = clear that pending bit
//            O_int        interrupt request to decode
//            O_int_vector index of the requested source
//            O_pending    pending register readback
//            O_mask       mask register readback
//            O_busy       high while in REQ or HOLD
// Revision : 1.0 - initial release
// ============================================================================
module ceespu_int_ctrl #(
  parameter int VEC_W   = 2,
  parameter int NUM_SRC = 4,
  parameter int HOLDOFF = 2
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_SRC-1:0] I_irq,
  input  logic               I_int_ack,
  input  logic               I_mask_we,
  input  logic [NUM_SRC-1:0] I_mask_wdata,
  input  logic               I_clr_we,
  input  logic [NUM_SRC-1:0] I_clr_wdata,
  output logic               O_int,
  output logic [VEC_W-1:0]   O_int_vector,
  output logic [NUM_SRC-1:0] O_pending,
  output logic [NUM_SRC-1:0] O_mask,
  output logic               O_busy
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_HOLD = 2'd2;

  // HOLD is entered with HOLDOFF-1 so that exactly HOLDOFF cycles are spent there.
  localparam logic [3:0] c_HOLD_INIT = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  logic [1:0]         r_state, w_state_nxt;
  logic               r_int, w_int_nxt;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;
  logic               r_busy, w_busy_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_eligible;
  logic [VEC_W-1:0]   w_sel_idx;
  logic               w_any;
  logic               w_ack_take;

  assign w_eligible = r_pending & r_mask;
  // Ack only counts while a request is outstanding.
  assign w_ack_take = (r_state == c_ST_REQ) & I_int_ack;

  // Fixed priority: scan from the top down so the lowest set index wins.
  always_comb begin
    w_sel_idx = '0;
    w_any     = |w_eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel_idx = VEC_W'(i);
    end
  end

  // Mask register
  always_ff @(posedge I_clk) begin
    if (I_rst)          r_mask <= '1;
    else if (I_mask_we) r_mask <= I_mask_wdata;
  end

`ifdef CEESPU_INT_LEVEL_EN
  // Level mode: pending is just the line, registered once.
  always_ff @(posedge I_clk) begin
    if (I_rst) r_pending <= '0;
    else       r_pending <= I_irq;
  end

  logic w_unused;
  assign w_unused = ^{I_clr_we, I_clr_wdata};
`else
  logic [NUM_SRC-1:0] r_irq_q;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_sw_clr;

  assign w_rise    = I_irq & ~r_irq_q;
  assign w_ack_clr = w_ack_take ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_vec) : '0;
  assign w_sw_clr  = I_clr_we ? I_clr_wdata : '0;

  // A new edge always wins over either kind of clear in the same cycle.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_irq_q   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_q   <= I_irq;
      r_pending <= w_rise | (r_pending & ~w_ack_clr & ~w_sw_clr);
    end
  end
`endif

  // FSM: state and registered outputs
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= c_ST_IDLE;
      r_int   <= 1'b0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_int   <= w_int_nxt;
      r_vec   <= w_vec_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_any) w_state_nxt = c_ST_REQ;
      c_ST_REQ:  if (w_ack_take) w_state_nxt = (HOLDOFF == 0) ? c_ST_IDLE : c_ST_HOLD;
      c_ST_HOLD: if (r_cnt == 4'd0) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM: next values of the registered outputs. The vector is captured once
  // in IDLE and never re-arbitrated while the request is up.
  always_comb begin
    w_int_nxt = r_int;
    w_vec_nxt = r_vec;
    w_cnt_nxt = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any) begin
          w_int_nxt = 1'b1;
          w_vec_nxt = w_sel_idx;
        end
      end
      c_ST_REQ: begin
        if (w_ack_take) begin
          w_int_nxt = 1'b0;
          w_cnt_nxt = c_HOLD_INIT;
        end
      end
      c_ST_HOLD: begin
        w_int_nxt = 1'b0;
        if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
      end
      default: begin
        w_int_nxt = 1'b0;
        w_cnt_nxt = 4'd0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != c_ST_IDLE);
  end

  assign O_int        = r_int;
  assign O_int_vector = r_vec;
  assign O_pending    = r_pending;
  assign O_mask       = r_mask;
  assign O_busy       = r_busy;

endmodule
`default_nettype wire
